// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-bit synchronous FIFO and its read-side controller.
//   DATA_W      : default FIFO/stream data width
//   fifo_data_t : one FIFO word
//   occ_state_t : occupancy of the reader's 2-entry output buffer
package fifo_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] fifo_data_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry output buffer for fifo_reader. Absorbs the FIFO's one-cycle read
// latency so the downstream stream can run at one byte per cycle.
//   clk, reset  : clock, asynchronous active-low reset
//   wr_en       : a byte arrives this cycle on wr_data (from the FIFO)
//   wr_data     : arriving byte
//   m_ready     : downstream accepts m_data this cycle
//   m_valid     : a byte is buffered; m_data is the oldest one
//   m_data      : oldest buffered byte, registered
//   count       : number of buffered bytes (0..2)
//   fire        : m_valid && m_ready
//
// state      | meaning
// OCC_EMPTY  | nothing buffered, m_valid low
// OCC_ONE    | one byte, held in slots[head]
// OCC_TWO    | two bytes, slots[head] is the oldest
module reader_skid_buf #(
  parameter int DATA_W = fifo_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        count,
  output logic              fire
);
  import fifo_pkg::*;

  occ_state_t        state;
  occ_state_t        state_next;
  logic              head;
  logic              wr_slot;
  logic [DATA_W-1:0] slots [2];

  assign count   = state;
  assign m_valid = (state != OCC_EMPTY);
  assign m_data  = slots[head];
  assign fire    = m_valid && m_ready;

  // Slot after a same-cycle pop is (head+1)+(count-1) = head+count, so the
  // write slot does not depend on fire.
  assign wr_slot = head ^ count[0];

  always_comb begin
    state_next = state;
    case (state)
      OCC_EMPTY: if (wr_en) state_next = OCC_ONE;
      OCC_ONE: begin
        if (wr_en && !fire)      state_next = OCC_TWO;
        else if (!wr_en && fire) state_next = OCC_EMPTY;
      end
      OCC_TWO:   if (fire && !wr_en) state_next = OCC_ONE;
      default:   state_next = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= OCC_EMPTY;
      head     <= 1'b0;
      slots[0] <= '0;
      slots[1] <= '0;
    end else begin
      state <= state_next;
      if (fire)  head           <= ~head;
      if (wr_en) slots[wr_slot] <= wr_data;
    end
  end

  // Request gating upstream guarantees a capture into a full buffer only
  // coincides with a pop.
  overflow_chk: assert property (@(posedge clk) disable iff (!reset)
    !(wr_en && (state == OCC_TWO) && !fire));

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the 8-bit synchronous FIFO. Issues pop requests
// while the FIFO is non-empty and there is room, captures the registered read
// data one cycle later and presents it on a valid/ready byte stream.
//   clk, reset     : clock, asynchronous active-low reset
//   enable         : permits new FIFO reads (level)
//   fifo_empty     : FIFO empty flag
//   fifo_read_req  : pop request to the FIFO (combinational)
//   fifo_read_data : FIFO read data, valid the cycle after a request
//   m_valid/m_data : output byte stream, driven from registers only
//   m_ready        : downstream accepts
//   pop_count      : bytes delivered since reset, wraps
module fifo_reader #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_read_req,
  input  logic [DATA_W-1:0] fifo_read_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  pop_count
);
  import fifo_pkg::*;

  logic       inflight;
  logic [1:0] count;
  logic       fire;
  logic [2:0] occupied;

  // Buffered bytes plus the byte already requested must leave room for one more.
  assign occupied = {1'b0, count} + {2'b0, inflight};

  // Gated by reset so no pop reaches the FIFO while both are held in reset.
  assign fifo_read_req = reset && enable && !fifo_empty &&
                         ((occupied < 3'd2) || fire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight  <= 1'b0;
      pop_count <= '0;
    end else begin
      inflight <= fifo_read_req;
      if (fire) pop_count <= pop_count + CNT_W'(1);
    end
  end

  reader_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight),
    .wr_data (fifo_read_data),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .count   (count),
    .fire    (fire)
  );

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic       fifo_read_req, fifo_read_req8;
  logic [7:0] fifo_read_data = 8'h00;
  logic       m_valid, m_valid8;
  logic [7:0] m_data, m_data8;
  logic       m_ready = 1'b0;
  logic [15:0] pop_count;
  logic [7:0]  pop_count8;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read_req(fifo_read_req), .fifo_read_data(fifo_read_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .pop_count(pop_count)
  );

  fifo_reader #(.DATA_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read_req(fifo_read_req8), .fifo_read_data(fifo_read_data),
    .m_valid(m_valid8), .m_data(m_data8), .m_ready(m_ready), .pop_count(pop_count8)
  );

  // Behavioural FIFO: 256 entries, registered read data.
  logic [7:0] fmem [256];
  logic [7:0] wr_ptr = 8'h00, rd_ptr = 8'h00;
  int         level = 0;
  logic       push_en = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       fifo_clr = 1'b0;

  assign fifo_empty = (level == 0);

  always @(posedge clk) begin
    if (fifo_clr) begin
      wr_ptr <= 8'h00;
      rd_ptr <= 8'h00;
      level  <= 0;
      fifo_read_data <= 8'h00;
    end else begin
      if (push_en) begin
        fmem[wr_ptr] <= push_data;
        wr_ptr <= wr_ptr + 8'd1;
      end
      if (fifo_read_req) begin
        fifo_read_data <= fmem[rd_ptr];
        rd_ptr <= rd_ptr + 8'd1;
      end
      level <= level + int'(push_en) - int'(fifo_read_req);
    end
  end

  // Reference model: bytes pushed, in order; requests and deliveries since reset.
  logic [7:0] exp_q [$];
  int tests = 0;
  int fails = 0;
  int n_req = 0;
  int n_fire = 0;
  int outstanding = 0;
  logic cyc_req, cyc_fire, exp_have;
  logic [7:0] exp_byte;

  task automatic step(input logic en, input logic rdy, input logic push, input logic [7:0] d);
    @(negedge clk);
    enable = en; m_ready = rdy; push_en = push; push_data = d;
    if (push) exp_q.push_back(d);
    #1;
    cyc_req  = fifo_read_req;
    cyc_fire = m_valid && m_ready;
    outstanding = n_req - n_fire;
    exp_have = 1'b0;
    if (cyc_fire) begin
      n_fire++;
      if (exp_q.size() > 0) begin
        exp_byte = exp_q.pop_front();
        exp_have = 1'b1;
      end
    end
    if (cyc_req) n_req++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; fifo_clr = 1'b1; enable = 1'b0; m_ready = 1'b0; push_en = 1'b0;
    exp_q.delete(); n_req = 0; n_fire = 0;
    @(negedge clk);
    fifo_clr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'(i + 1));
      tests++;
      if (fifo_read_req !== 1'b0 || fifo_read_req8 !== 1'b0) begin
        fails++; $display("FAIL reset_req: got %b/%b want 0", fifo_read_req, fifo_read_req8);
      end
      tests++;
      if (m_valid !== 1'b0 || m_data !== 8'h00) begin
        fails++; $display("FAIL reset_out: m_valid=%b m_data=%h want 0/00", m_valid, m_data);
      end
      tests++;
      if (pop_count !== 16'd0 || pop_count8 !== 8'd0) begin
        fails++; $display("FAIL reset_cnt: pop_count=%0d/%0d want 0", pop_count, pop_count8);
      end
    end
    apply_reset();
  endtask

  task automatic test_stream();
    int first_req, first_valid;
    bit gap;
    apply_reset();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 8'(i));
    first_req = -1; first_valid = -1; gap = 0;
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      if (cyc_req && first_req < 0) first_req = c;
      if (m_valid && first_valid < 0) first_valid = c;
      if (first_valid >= 0 && n_fire < 16 && !m_valid && !cyc_fire) gap = 1;
      if (cyc_fire) begin
        tests++;
        if (!exp_have || m_data !== exp_byte) begin
          fails++; $display("FAIL stream_data: got %h want %h (have=%b)", m_data, exp_byte, exp_have);
        end
      end
    end
    tests++;
    if (first_req != 0 || first_valid != first_req + 2) begin
      fails++; $display("FAIL stream_latency: req@%0d valid@%0d want 0/2", first_req, first_valid);
    end
    tests++;
    if (gap) begin
      fails++; $display("FAIL stream_gap: m_valid dropped mid-stream, want 16 consecutive");
    end
    tests++;
    if (n_fire != 16 || pop_count !== 16'd16) begin
      fails++; $display("FAIL stream_count: fires=%0d pop_count=%0d want 16", n_fire, pop_count);
    end
  endtask

  task automatic test_backpressure();
    int reqs;
    bit started, gap;
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i));
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      if (cyc_req) reqs++;
      if (m_valid) begin
        tests++;
        if (m_data !== 8'hA0) begin
          fails++; $display("FAIL bp_hold: m_data=%h want a0 at stall cycle %0d", m_data, c);
        end
      end
    end
    tests++;
    if (reqs != 2) begin
      fails++; $display("FAIL bp_reqs: got %0d requests want 2", reqs);
    end
    started = 0; gap = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      tests++;
      if (outstanding > 2) begin
        fails++; $display("FAIL bp_occupancy: outstanding=%0d want <=2", outstanding);
      end
      if (cyc_fire) begin
        started = 1;
        tests++;
        if (!exp_have || m_data !== exp_byte) begin
          fails++; $display("FAIL bp_data: got %h want %h", m_data, exp_byte);
        end
      end else if (started && n_fire < 8) gap = 1;
    end
    tests++;
    if (gap || n_fire != 8 || pop_count !== 16'd8) begin
      fails++; $display("FAIL bp_drain: gap=%b fires=%0d pop_count=%0d want 0/8/8", gap, n_fire, pop_count);
    end
  endtask

  task automatic test_random();
    int pushed;
    logic p;
    apply_reset();
    pushed = 0;
    for (int c = 0; c < 6000 && n_fire < 300; c++) begin
      p = (pushed < 300) && (level < 250) && ($urandom_range(0, 3) != 0);
      step(1'b1, 1'($urandom_range(0, 1)), p, 8'($urandom_range(0, 255)));
      if (p) pushed++;
      tests++;
      if (outstanding > 2) begin
        fails++; $display("FAIL rand_occupancy: outstanding=%0d want <=2", outstanding);
      end
      tests++;
      if (fifo_read_req8 !== fifo_read_req || m_valid8 !== m_valid ||
          (m_valid && m_data8 !== m_data)) begin
        fails++; $display("FAIL rand_variant: req %b/%b valid %b/%b data %h/%h", fifo_read_req8,
                          fifo_read_req, m_valid8, m_valid, m_data8, m_data);
      end
      if (cyc_fire) begin
        tests++;
        if (!exp_have || m_data !== exp_byte) begin
          fails++; $display("FAIL rand_data: byte %0d got %h want %h", n_fire, m_data, exp_byte);
        end
      end
    end
    step(1'b1, 1'b0, 1'b0, 8'h00);
    tests++;
    if (n_fire != 300 || pop_count !== 16'd300) begin
      fails++; $display("FAIL rand_count: fires=%0d pop_count=%0d want 300", n_fire, pop_count);
    end
    tests++;
    if (pop_count8 !== 8'd44) begin
      fails++; $display("FAIL rand_wrap: pop_count8=%0d want 44", pop_count8);
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 8'h30 + 8'(i));
    for (int c = 0; c < 40; c++) begin
      step(!(c >= 4 && c < 9), 1'b1, 1'b0, 8'h00);
      if (c >= 4 && c < 9) begin
        tests++;
        if (cyc_req) begin
          fails++; $display("FAIL en_window: request at cycle %0d with enable low", c);
        end
      end
      if (c == 8) begin
        tests++;
        if (n_req == 0 || n_req != n_fire) begin
          fails++; $display("FAIL en_drain: reqs=%0d delivered=%0d want equal, nonzero", n_req, n_fire);
        end
      end
      if (cyc_fire) begin
        tests++;
        if (!exp_have || m_data !== exp_byte) begin
          fails++; $display("FAIL en_data: got %h want %h", m_data, exp_byte);
        end
      end
    end
    tests++;
    if (n_fire != 20 || pop_count !== 16'd20) begin
      fails++; $display("FAIL en_count: fires=%0d pop_count=%0d want 20", n_fire, pop_count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'hC0 + 8'(i));
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    tests++;
    if (!(cyc_fire && cyc_req)) begin
      fails++; $display("FAIL mid_setup: fire=%b req=%b want 1/1 with full buffer", cyc_fire, cyc_req);
    end
    reset = 1'b0; fifo_clr = 1'b1;
    #1;
    tests++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_read_req !== 1'b0 || pop_count !== 16'd0) begin
      fails++; $display("FAIL mid_reset: valid=%b data=%h req=%b pop=%0d want 0", m_valid, m_data,
                        fifo_read_req, pop_count);
    end
    exp_q.delete(); n_req = 0; n_fire = 0;
    @(negedge clk); fifo_clr = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 8'h50 + 8'(i));
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      if (cyc_fire) begin
        tests++;
        if (!exp_have || m_data !== exp_byte) begin
          fails++; $display("FAIL mid_data: got %h want %h", m_data, exp_byte);
        end
      end
    end
    tests++;
    if (n_fire != 6 || pop_count !== 16'd6) begin
      fails++; $display("FAIL mid_count: fires=%0d pop_count=%0d want 6", n_fire, pop_count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
